// File: rtl/risc_controller.sv
// Simple-RISC instruction sequencer: 8-phase fetch/execute cycle with a halted state,
// decoding bus/register strobes from phase, IR opcode and the ALU zero flag.
module risc_controller #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic             is_zero,
  input  logic             resume,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             data_e,
  output logic             wr,
  output logic             halt,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    PhInstAddr  = 3'd0,
    PhInstFetch = 3'd1,
    PhInstLoad  = 3'd2,
    PhIdle      = 3'd3,
    PhOpAddr    = 3'd4,
    PhOpFetch   = 3'd5,
    PhAluOp     = 3'd6,
    PhStore     = 3'd7
  } phase_e;

  localparam logic [2:0] OpHlt = 3'b000;
  localparam logic [2:0] OpSkz = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpAnd = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpLda = 3'b101;
  localparam logic [2:0] OpSto = 3'b110;
  localparam logic [2:0] OpJmp = 3'b111;

  phase_e            phase_q, phase_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  phase_e            dec_phase;
  logic              alu_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PhInstAddr;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    if (halted_q) begin
      if (resume) begin
        phase_d  = PhInstAddr;
        halted_d = 1'b0;
      end
    end else if (phase_q == PhOpAddr && opcode == OpHlt) begin
      // HLT retires on entry to the halted state; phase stays parked at OP_ADDR
      halted_d = 1'b1;
      cnt_d    = cnt_q + CNT_W'(1);
    end else begin
      phase_d = phase_e'(phase_q + 3'd1);
      if (phase_q == PhStore) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign alu_op = (opcode == OpAdd) || (opcode == OpAnd) ||
                  (opcode == OpXor) || (opcode == OpLda);

  // During reset the strobes decode as phase 0 regardless of the held phase
  assign dec_phase = rst ? PhInstAddr : phase_q;

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    wr     = 1'b0;
    halt   = 1'b0;
    if (!rst && halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (dec_phase)
        PhInstAddr: sel = 1'b1;
        PhInstFetch: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PhInstLoad, PhIdle: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PhOpAddr: begin
          inc_pc = 1'b1;
          halt   = (opcode == OpHlt);
        end
        PhOpFetch: rd = alu_op;
        PhAluOp: begin
          rd     = alu_op;
          inc_pc = (opcode == OpSkz) && is_zero;
          ld_pc  = (opcode == OpJmp);
          data_e = (opcode == OpSto);
        end
        PhStore: begin
          rd     = alu_op;
          inc_pc = (opcode == OpJmp);
          ld_pc  = (opcode == OpJmp);
          ld_ac  = alu_op;
          data_e = (opcode == OpSto);
          wr     = (opcode == OpSto);
        end
      endcase
    end
  end

  assign phase     = phase_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_risc_controller.sv
// Directed bench for risc_controller: per-phase strobe tables for each opcode class,
// halt/resume, mid-instruction reset and counter wrap on a narrow-counter instance.
module tb_risc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       is_zero;
  logic       resume;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
  logic [2:0] phase;
  logic [7:0] instr_cnt;

  logic       n_sel, n_rd, n_ld_ir, n_inc_pc, n_ld_pc, n_ld_ac, n_data_e, n_wr, n_halt;
  logic [2:0] n_phase;
  logic [1:0] n_cnt;

  logic [8:0] strobes;
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_cnt;

  assign strobes = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt};

  always #5 clk = ~clk;

  risc_controller #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .is_zero(is_zero), .resume(resume),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc), .ld_ac(ld_ac),
    .data_e(data_e), .wr(wr), .halt(halt), .phase(phase), .instr_cnt(instr_cnt)
  );

  risc_controller #(.CNT_W(2)) dut_narrow (
    .clk(clk), .rst(rst), .opcode(opcode), .is_zero(is_zero), .resume(resume),
    .sel(n_sel), .rd(n_rd), .ld_ir(n_ld_ir), .inc_pc(n_inc_pc), .ld_pc(n_ld_pc),
    .ld_ac(n_ld_ac), .data_e(n_data_e), .wr(n_wr), .halt(n_halt), .phase(n_phase),
    .instr_cnt(n_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe order: sel rd ld_ir inc_pc ld_pc ld_ac data_e wr halt
  task automatic test_reset();
    rst = 1'b1; opcode = 3'b000; is_zero = 1'b1; resume = 1'b0;
    tick(); tick();
    total++; if (phase !== 3'd0) begin bad++; $display("FAIL reset_phase got %0d want 0", phase); end
    total++; if (instr_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", instr_cnt); end
    total++; if (strobes !== 9'b100000000) begin
      bad++; $display("FAIL reset_strobes got %b want 100000000", strobes);
    end
    rst = 1'b0; opcode = 3'b010; is_zero = 1'b0;
    for (int p = 0; p < 8; p++) begin
      total++; if (phase !== p[2:0]) begin bad++; $display("FAIL seq_phase got %0d want %0d", phase, p); end
      total++; if (sel !== (p < 4)) begin bad++; $display("FAIL seq_sel p%0d got %b want %b", p, sel, p < 4); end
      total++; if (ld_ir !== (p == 2 || p == 3)) begin
        bad++; $display("FAIL seq_ld_ir p%0d got %b want %b", p, ld_ir, (p == 2 || p == 3));
      end
      tick();
    end
    exp_cnt = 8'd1;
    total++; if (instr_cnt !== exp_cnt) begin bad++; $display("FAIL seq_cnt got %0d want %0d", instr_cnt, exp_cnt); end
  endtask

  task automatic test_add();
    logic [8:0] t [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                          9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000};
    opcode = 3'b010;
    for (int p = 0; p < 8; p++) begin
      total++; if (phase !== p[2:0]) begin bad++; $display("FAIL add_phase got %0d want %0d", phase, p); end
      total++; if (strobes !== t[p]) begin bad++; $display("FAIL add_strobes p%0d got %b want %b", p, strobes, t[p]); end
      if (p == 7) begin
        total++; if (instr_cnt !== exp_cnt) begin bad++; $display("FAIL add_cnt_pre got %0d want %0d", instr_cnt, exp_cnt); end
      end
      resume = (p == 3);  // resume while running must be ignored
      tick();
      resume = 1'b0;
    end
    exp_cnt++;
    total++; if (instr_cnt !== exp_cnt) begin bad++; $display("FAIL add_cnt got %0d want %0d", instr_cnt, exp_cnt); end
  endtask

  task automatic test_skz();
    logic [8:0] tz [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                           9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000};
    logic [8:0] tn [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                           9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000};
    opcode = 3'b001;
    for (int i = 0; i < 2; i++) begin
      is_zero = (i == 0);
      for (int p = 0; p < 8; p++) begin
        total++; if (strobes !== (i == 0 ? tz[p] : tn[p])) begin
          bad++; $display("FAIL skz_z%0d_strobes p%0d got %b want %b", 1 - i, p, strobes, (i == 0 ? tz[p] : tn[p]));
        end
        tick();
      end
      exp_cnt++;
    end
    is_zero = 1'b0;
    total++; if (instr_cnt !== exp_cnt) begin bad++; $display("FAIL skz_cnt got %0d want %0d", instr_cnt, exp_cnt); end
  endtask

  task automatic test_sto();
    logic [8:0] t [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                          9'b000100000, 9'b000000000, 9'b000000100, 9'b000000110};
    opcode = 3'b110;
    for (int p = 0; p < 8; p++) begin
      total++; if (strobes !== t[p]) begin bad++; $display("FAIL sto_strobes p%0d got %b want %b", p, strobes, t[p]); end
      tick();
    end
    exp_cnt++;
  endtask

  task automatic test_jmp();
    logic [8:0] t [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                          9'b000100000, 9'b000000000, 9'b000010000, 9'b000110000};
    opcode = 3'b111;
    is_zero = 1'b1;
    for (int p = 0; p < 8; p++) begin
      total++; if (strobes !== t[p]) begin bad++; $display("FAIL jmp_strobes p%0d got %b want %b", p, strobes, t[p]); end
      tick();
    end
    is_zero = 1'b0;
    exp_cnt++;
    total++; if (instr_cnt !== exp_cnt) begin bad++; $display("FAIL jmp_cnt got %0d want %0d", instr_cnt, exp_cnt); end
  endtask

  task automatic test_halt();
    opcode = 3'b000;
    for (int p = 0; p < 4; p++) tick();
    total++; if (phase !== 3'd4) begin bad++; $display("FAIL hlt_phase4 got %0d want 4", phase); end
    total++; if (strobes !== 9'b000100001) begin bad++; $display("FAIL hlt_p4_strobes got %b want 000100001", strobes); end
    tick();
    exp_cnt++;
    for (int i = 0; i < 20; i++) begin
      opcode = i[2:0];  // opcode ignored while halted
      is_zero = i[0];
      #1;
      total++; if (phase !== 3'd4 || strobes !== 9'b000000001 || instr_cnt !== exp_cnt) begin
        bad++; $display("FAIL halted_%0d got ph=%0d st=%b cnt=%0d want ph=4 st=000000001 cnt=%0d",
                        i, phase, strobes, instr_cnt, exp_cnt);
      end
      tick();
    end
    opcode = 3'b010; is_zero = 1'b0; resume = 1'b1;
    tick();
    resume = 1'b0;
    total++; if (phase !== 3'd0 || strobes !== 9'b100000000 || instr_cnt !== exp_cnt) begin
      bad++; $display("FAIL resume got ph=%0d st=%b cnt=%0d want ph=0 st=100000000 cnt=%0d",
                      phase, strobes, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    opcode = 3'b010;
    for (int p = 0; p < 5; p++) tick();
    total++; if (phase !== 3'd5) begin bad++; $display("FAIL mid_phase5 got %0d want 5", phase); end
    rst = 1'b1;
    #1;
    total++; if (strobes !== 9'b100000000) begin bad++; $display("FAIL mid_rst_strobes got %b want 100000000", strobes); end
    tick();
    rst = 1'b0;
    total++; if (phase !== 3'd0 || instr_cnt !== 8'd0 || n_cnt !== 2'd0) begin
      bad++; $display("FAIL mid_rst got ph=%0d cnt=%0d ncnt=%0d want 0 0 0", phase, instr_cnt, n_cnt);
    end
    for (int i = 0; i < 40; i++) tick();
    total++; if (instr_cnt !== 8'd5) begin bad++; $display("FAIL five_cnt got %0d want 5", instr_cnt); end
    total++; if (n_cnt !== 2'd1) begin bad++; $display("FAIL wrap_cnt got %0d want 1", n_cnt); end
    total++; if (phase !== 3'd0) begin bad++; $display("FAIL five_phase got %0d want 0", phase); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_skz();
    test_sto();
    test_jmp();
    test_halt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
